// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocks out {parity, byte} on device-generated
// clock edges, samples the device ACK and reports done / ack error / timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       CLK_100MHZ,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRts,
        StStart,
        StData,
        StStop,
        StAck,
        StWait
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [8:0]            sr_q;
    logic [3:0]            n_q;
    logic                  c_oe_q;
    logic                  d_oe_q;
    logic                  ack_bad_q;
    logic                  done_q;
    logic                  ack_err_q;
    logic                  tout_q;
    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q;

    logic fall;
    logic active;
    logic timed_out;

    // Open-drain: only ever pull low.
    assign ps2c = c_oe_q ? 1'b0 : 1'bz;
    assign ps2d = d_oe_q ? 1'b0 : 1'bz;

    assign tx_idle      = (state_q == StIdle);
    assign tx_done_tick = done_q;
    assign ack_err      = ack_err_q;
    assign timeout_err  = tout_q;

    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= '1;
            fclk_q   <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
            filt_q   <= {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
            if (&filt_q) begin
                fclk_q <= 1'b1;
            end else if (filt_q == '0) begin
                fclk_q <= 1'b0;
            end
        end
    end

    // fall is high in the single cycle where fclk_q is about to drop.
    assign fall      = fclk_q && (filt_q == '0);
    assign active    = state_q inside {StStart, StData, StStop, StAck, StWait};
    assign timed_out = !fall && (cnt_q == TimeoutLast);

    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sr_q      <= '0;
            n_q       <= '0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            ack_bad_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            tout_q    <= 1'b0;
            if (active) begin
                cnt_q <= fall ? '0 : cnt_q + CntW'(1);
            end
            if (active && timed_out) begin
                c_oe_q  <= 1'b0;
                d_oe_q  <= 1'b0;
                tout_q  <= 1'b1;
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        c_oe_q <= 1'b0;
                        d_oe_q <= 1'b0;
                        if (wr_ps2) begin
                            sr_q    <= {~^din, din};
                            cnt_q   <= '0;
                            c_oe_q  <= 1'b1;
                            state_q <= StRts;
                        end
                    end
                    StRts: begin
                        if (cnt_q == InhibitLast) begin
                            cnt_q   <= '0;
                            c_oe_q  <= 1'b0;
                            d_oe_q  <= 1'b1;
                            state_q <= StStart;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StStart: begin
                        if (fall) begin
                            d_oe_q  <= ~sr_q[0];
                            sr_q    <= {1'b0, sr_q[8:1]};
                            n_q     <= 4'd1;
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (fall) begin
                            d_oe_q <= ~sr_q[0];
                            sr_q   <= {1'b0, sr_q[8:1]};
                            n_q    <= n_q + 4'd1;
                            if (n_q == 4'd8) begin
                                state_q <= StStop;
                            end
                        end
                    end
                    StStop: begin
                        if (fall) begin
                            d_oe_q  <= 1'b0;
                            state_q <= StAck;
                        end
                    end
                    StAck: begin
                        if (fall) begin
                            ack_bad_q <= d_sync_q[1];
                            state_q   <= StWait;
                        end
                    end
                    StWait: begin
                        if (fclk_q && d_sync_q[1]) begin
                            done_q    <= 1'b1;
                            ack_err_q <= ack_bad_q;
                            state_q   <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device BFM clocks the frame in and a
// parity/frame reference model checks what the device received.
module tb_ps2_host_tx;

    localparam int unsigned Inh  = 100;
    localparam int unsigned Tmo  = 2000;
    localparam int unsigned Half = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       idle;
    logic       done;
    logic       aerr;
    logic       terr;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int aerr_cnt = 0;
    int aerr_alone = 0;
    int tmo_cnt = 0;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inh),
        .TIMEOUT_CYCLES(Tmo),
        .FILTER_LEN    (8)
    ) dut (
        .CLK_100MHZ  (clk),
        .reset       (rst_n),
        .wr_ps2      (wr),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (idle),
        .tx_done_tick(done),
        .ack_err     (aerr),
        .timeout_err (terr)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (aerr) begin
            aerr_cnt++;
            if (!done) aerr_alone++;
        end
        if (terr) tmo_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What the device should see: 8 data bits LSB first, odd parity, stop = 1.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic start_req(input logic [7:0] b);
        check("idle_before_req", 32'(idle), 32'd1);
        din = b;
        wr  = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("idle_after_accept", 32'(idle), 32'd0);
    endtask

    // Wait for RTS, check its length and the start bit, then clock 11 edges.
    task automatic device_xfer(input int ack_bit, input int glitch_after, input int wr_after,
                               input int abort_after, output logic [9:0] got);
        int t;
        int low;
        got = '0;
        t = 0;
        while (ps2c !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("rts_seen", 32'(ps2c), 32'd0);
        low = 0;
        while (ps2c === 1'b0 && low < int'(Inh) * 4) begin
            low++;
            @(negedge clk);
        end
        check("rts_len", 32'(low), 32'(Inh));
        check("start_bit", 32'(ps2d), 32'd0);
        for (int i = 1; i <= 11; i++) begin
            repeat (Half / 2) @(negedge clk);
            if (i == 11) dev_d_low = (ack_bit == 0);
            if (glitch_after > 0 && i == glitch_after + 1) begin
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
            end
            repeat (Half / 2) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (Half) @(negedge clk);
            if (i <= 10) got[i-1] = ps2d;
            if (i == wr_after) begin
                din = 8'hAA;
                wr  = 1'b1;
                @(negedge clk);
                wr = 1'b0;
            end
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
            if (i == abort_after) break;
        end
    endtask

    task automatic do_xfer(input logic [7:0] b, input int ack_bit, input int glitch_after,
                           input int wr_after);
        int d0;
        int a0;
        int t;
        logic [9:0] got;
        d0 = done_cnt;
        a0 = aerr_cnt;
        start_req(b);
        device_xfer(ack_bit, glitch_after, wr_after, 0, got);
        check("frame", 32'(got), 32'(exp_frame(b)));
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("ack_err", 32'(aerr_cnt - a0), 32'(ack_bit));
        check("ack_err_with_done", 32'(aerr_alone), 32'd0);
        check("idle_end", 32'(idle), 32'd1);
        check("lines_released", {30'd0, ps2c, ps2d}, 32'd3);
    endtask

    initial begin
        int t;
        int cnt;
        int d0;
        int t0;
        logic [9:0] got;

        rst_n = 1'b0;
        wr    = 1'b0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_pulses", {29'd0, done, aerr, terr}, 32'd0);
        check("rst_lines", {30'd0, ps2c, ps2d}, 32'd3);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_xfer(8'hF4, 0, 0, 0);
        do_xfer(8'hFF, 0, 0, 0);
        do_xfer(8'h00, 0, 0, 0);
        do_xfer(8'h01, 0, 0, 0);
        do_xfer(8'h5A, 1, 0, 0);
        // Glitch on ps2c in the high phase after edge 4, stray request after edge 3.
        do_xfer(8'hF4, 0, 4, 3);

        for (int k = 0; k < 4; k++) begin
            do_xfer(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 0, 0);
        end

        // No device clock after RTS.
        d0 = done_cnt;
        t0 = tmo_cnt;
        start_req(8'hF4);
        t = 0;
        while (ps2c === 1'b0 && t < int'(Inh) * 4) begin
            @(negedge clk);
            t++;
        end
        check("tmo_start_bit", 32'(ps2d), 32'd0);
        cnt = 0;
        while (terr !== 1'b1 && cnt < int'(Tmo) + 50) begin
            @(negedge clk);
            cnt++;
        end
        check("tmo_cycles", 32'(cnt), 32'(Tmo));
        repeat (5) @(negedge clk);
        check("tmo_pulse_once", 32'(tmo_cnt - t0), 32'd1);
        check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        check("tmo_lines", {30'd0, ps2c, ps2d}, 32'd3);
        check("tmo_idle", 32'(idle), 32'd1);

        // Reset while bit 4 of 0x00 is being driven low.
        d0 = done_cnt;
        t0 = tmo_cnt;
        start_req(8'h00);
        device_xfer(0, 0, 0, 5, got);
        repeat (10) @(negedge clk);
        check("pre_rst_bit4_low", 32'(ps2d), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lines", {30'd0, ps2c, ps2d}, 32'd3);
        check("async_rst_idle", 32'(idle), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_pulses", 32'((done_cnt - d0) + (tmo_cnt - t0)), 32'd0);
        do_xfer(8'hF4, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter that sends one command byte to the mouse, e.g. 0xF4 "enable data reporting" after power-up.
- It is the opposite direction of the existing PS/2 receive path in the mouse controller.
- It shares the open-drain ps2c/ps2d lines with that receiver.
- While a transmission is in progress it reports busy so the receiver ignores line activity.

Parameters:
- INHIBIT_CYCLES, 12000: clock cycles ps2c is held low for request-to-send (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum wait between device clock falling edges, and for final line release (15 ms).
- FILTER_LEN, 8: consecutive equal ps2c samples required to change the filtered clock.

Ports:
- CLK_100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- wr_ps2  input  1  start request; one-cycle pulse, honoured only when tx_idle=1.
- din  input  8  command byte, captured on an accepted wr_ps2.
- ps2c  inout  1  PS/2 clock, open-drain: driven 0 or high-Z.
- ps2d  inout  1  PS/2 data, open-drain: driven 0 or high-Z.
- tx_idle  output  1  1 when in IDLE and able to accept wr_ps2.
- tx_done_tick  output  1  one-cycle pulse when a transfer completes, whether ACK is good or bad.
- ack_err  output  1  one-cycle pulse coincident with tx_done_tick when the device ACK bit was 1.
- timeout_err  output  1  one-cycle pulse when a transfer is aborted on timeout.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; ps2c and ps2d released to high-Z immediately.
  - tx_idle=1; tx_done_tick=0, ack_err=0, timeout_err=0.
  - Counters and shift register cleared.
- Line drive: internal enables c_oe and d_oe. A line is driven to 0 when its enable is 1 and is high-Z otherwise. The block never drives a 1.
- Clock filter:
  - ps2c passes through a 2-FF synchronizer, then a FILTER_LEN-deep shift register.
  - The filtered clock goes to 1 on all-ones, to 0 on all-zeros, and otherwise holds.
  - fall = filtered clock transitions 1->0, a one-cycle strobe.
- Accepting a request: on wr_ps2 in IDLE, load shift register {odd parity of din, din}. The parity bit is ~^din. Set the counter to 0 and go to RTS.
- States:
  - IDLE: c_oe=0, d_oe=0, tx_idle=1.
  - RTS: c_oe=1. After INHIBIT_CYCLES cycles, go to START.
  - START: d_oe=1 (start bit 0), c_oe=0. On fall, drive bit0 (d_oe=~bit0), set bit count n=1, go to DATA.
  - DATA: on each fall, shift and drive the next bit: data bits d1..d7, then parity. After the parity bit has been driven (n=9), go to STOP.
  - STOP: on fall, d_oe=0 (stop bit = released high), go to ACK.
  - ACK: on fall, sample the synchronized ps2d. ack_bad = sampled value. Go to WAIT.
  - WAIT: when filtered ps2c=1 and synchronized ps2d=1, pulse tx_done_tick. Pulse ack_err if ack_bad. Go to IDLE.
- Total device clock falling edges per transfer: 11, counted in START through ACK.
- Timeout:
  - In START, DATA, STOP, ACK and WAIT, a cycle counter resets on every fall.
  - If it reaches TIMEOUT_CYCLES, release both lines, pulse timeout_err (no tx_done_tick) and go to IDLE.
- Other boundary conditions:
  - wr_ps2 while not IDLE: ignored; din is not re-captured.
  - wr_ps2 in the same cycle a transfer finishes: ignored. A new request is accepted only from the following cycle, when tx_idle=1.
  - reset mid-transfer: lines released asynchronously; no done or error pulse.
  - tx_idle is combinational from state and goes to 0 the cycle after wr_ps2 is accepted.

Test Plan:
- din=0xF4, wr_ps2 pulse, BFM device clocking at 12.5 kHz with ACK=0:
  - ps2c held low 12000 cycles.
  - Device samples data bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - tx_done_tick=1 once, ack_err=0, tx_idle returns to 1.
- din=0xFF: device samples parity bit 1; din=0x00: parity bit 1; din=0x01: parity bit 0. Each transfer completes with ack_err=0.
- BFM returns ACK bit 1: tx_done_tick and ack_err pulse in the same cycle; lines released.
- No device clock after RTS: timeout_err pulses exactly TIMEOUT_CYCLES cycles after START entry; no tx_done_tick; ps2d is high-Z.
- Glitch test and ignored request:
  - 3-cycle low glitch on ps2c during DATA: no bit advance.
  - Second wr_ps2 with din=0xAA mid-transfer: ignored; the byte received by the device is still 0xF4.
- Assert reset low during DATA bit 4: ps2c and ps2d are high-Z in the same cycle; tx_idle=1. The next wr_ps2 completes normally.
